// File: rtl/tbu_ctrl_if.sv
// Handshake and PMU-side bus of the Viterbi traceback controller.
// The master modport is the controller's view; slave is the environment's view.
interface tbu_ctrl_if #(
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
);
  localparam int AW = $clog2(TBL);

  logic                sym_valid_i;
  logic                sym_ready_o;
  logic                acs_valid_o;
  logic                flush_i;
  logic [PM_WIDTH-1:0] pm_s0_i;
  logic [PM_WIDTH-1:0] pm_s1_i;
  logic [PM_WIDTH-1:0] pm_s2_i;
  logic [PM_WIDTH-1:0] pm_s3_i;
  logic [AW-1:0]       tb_addr_o;
  logic [3:0]          tb_data_i;
  logic                bit_o;
  logic                bit_valid_o;
  logic                bit_ready_i;
  logic                busy_o;
  logic                flush_done_o;

  modport master (
    input  sym_valid_i, flush_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i,
           tb_data_i, bit_ready_i,
    output sym_ready_o, acs_valid_o, tb_addr_o, bit_o, bit_valid_o,
           busy_o, flush_done_o
  );

  modport slave (
    output sym_valid_i, flush_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i,
           tb_data_i, bit_ready_i,
    input  sym_ready_o, acs_valid_o, tb_addr_o, bit_o, bit_valid_o,
           busy_o, flush_done_o
  );
endinterface

// File: rtl/tbu_ctrl.sv
// Traceback controller for the 4-state (K=3) Viterbi decoder: gates PMU writes,
// walks the survivor path from the best-metric state and emits decoded bits.
module tbu_ctrl #(
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tbu_ctrl_if.master   bus
);

  localparam int AW = $clog2(TBL);
  localparam int CW = $clog2(TBL + 1);

  localparam logic [AW-1:0] ADDR_LAST = AW'(TBL - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(TBL);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TRACE  = 3'd1;
  localparam logic [2:0] ST_EMIT   = 3'd2;
  localparam logic [2:0] ST_FTRACE = 3'd3;
  localparam logic [2:0] ST_FEMIT  = 3'd4;

  logic [2:0]     state_q,      state_d;
  logic [CW-1:0]  pend_cnt_q,   pend_cnt_d;
  logic           flush_req_q,  flush_req_d;
  logic [1:0]     cur_q,        cur_d;
  logic           first_q,      first_d;
  logic [AW-1:0]  tb_addr_q,    tb_addr_d;
  logic [AW-1:0]  idx_q,        idx_d;
  logic [TBL-1:0] dec_buf_q,    dec_buf_d;
  logic           bit_q,        bit_d;
  logic           bit_valid_q,  bit_valid_d;
  logic           flush_done_q, flush_done_d;
  logic           busy_q,       busy_d;

  logic           sym_ready_s;
  logic           write_s;
  logic [1:0]     cur_eff_s;
  logic [1:0]     pred_s;
  logic [AW-1:0]  start_idx_s;

  // Lowest path metric wins; ties resolve to the lower state index.
  function automatic logic [1:0] argmin4(
    input logic [PM_WIDTH-1:0] m0,
    input logic [PM_WIDTH-1:0] m1,
    input logic [PM_WIDTH-1:0] m2,
    input logic [PM_WIDTH-1:0] m3
  );
    logic [1:0]          i01;
    logic [1:0]          i23;
    logic [PM_WIDTH-1:0] v01;
    logic [PM_WIDTH-1:0] v23;
    if (m1 < m0) begin
      i01 = 2'd1;
      v01 = m1;
    end else begin
      i01 = 2'd0;
      v01 = m0;
    end
    if (m3 < m2) begin
      i23 = 2'd3;
      v23 = m3;
    end else begin
      i23 = 2'd2;
      v23 = m2;
    end
    if (v23 < v01) begin
      return i23;
    end else begin
      return i01;
    end
  endfunction

  // Handshake gating and survivor-path step for the current traceback cycle.
  always_comb begin
    sym_ready_s = rst_n && (state_q == ST_IDLE) && !flush_req_q;
    write_s     = bus.sym_valid_i && sym_ready_s;
    if (first_q) begin
      cur_eff_s = argmin4(bus.pm_s0_i, bus.pm_s1_i, bus.pm_s2_i, bus.pm_s3_i);
    end else begin
      cur_eff_s = cur_q;
    end
    pred_s      = {cur_eff_s[0], bus.tb_data_i[cur_eff_s]};
    start_idx_s = AW'(CNT_FULL - pend_cnt_q);
  end

  // Next-state logic for the FSM, counters, decision buffer and outputs.
  always_comb begin
    state_d      = state_q;
    pend_cnt_d   = pend_cnt_q;
    flush_req_d  = flush_req_q;
    cur_d        = cur_q;
    first_d      = first_q;
    tb_addr_d    = tb_addr_q;
    idx_d        = idx_q;
    dec_buf_d    = dec_buf_q;
    bit_d        = bit_q;
    bit_valid_d  = bit_valid_q;
    flush_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_s) begin
          pend_cnt_d = pend_cnt_q + CW'(1);
          if (bus.flush_i) begin
            flush_req_d = 1'b1;
          end else begin
            flush_req_d = flush_req_q;
          end
          if (pend_cnt_q + CW'(1) == CNT_FULL) begin
            state_d   = ST_TRACE;
            tb_addr_d = ADDR_LAST;
            first_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (flush_req_q || bus.flush_i) begin
          if (pend_cnt_q != '0) begin
            state_d     = ST_FTRACE;
            flush_req_d = 1'b1;
            tb_addr_d   = ADDR_LAST;
            first_d     = 1'b1;
          end else begin
            flush_done_d = 1'b1;
            flush_req_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TRACE, ST_FTRACE: begin
        if (bus.flush_i) begin
          flush_req_d = 1'b1;
        end else begin
          flush_req_d = flush_req_q;
        end
        dec_buf_d[tb_addr_q] = cur_eff_s[1];
        cur_d                = pred_s;
        first_d              = 1'b0;
        if (tb_addr_q == '0) begin
          bit_valid_d = 1'b1;
          if (state_q == ST_TRACE) begin
            state_d = ST_EMIT;
            bit_d   = cur_eff_s[1];
          end else begin
            // Oldest still-undecoded stage sits at TBL-pend_cnt.
            state_d = ST_FEMIT;
            idx_d   = start_idx_s;
            bit_d   = dec_buf_d[start_idx_s];
          end
        end else begin
          tb_addr_d = tb_addr_q - AW'(1);
        end
      end

      ST_EMIT: begin
        if (bus.flush_i) begin
          flush_req_d = 1'b1;
        end else begin
          flush_req_d = flush_req_q;
        end
        if (bus.bit_ready_i) begin
          bit_valid_d = 1'b0;
          pend_cnt_d  = pend_cnt_q - CW'(1);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end

      ST_FEMIT: begin
        if (bus.bit_ready_i) begin
          if (idx_q == ADDR_LAST) begin
            bit_valid_d  = 1'b0;
            pend_cnt_d   = '0;
            flush_done_d = 1'b1;
            flush_req_d  = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
            bit_d = dec_buf_q[idx_d];
          end
        end else begin
          state_d = ST_FEMIT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        pend_cnt_d  = '0;
        flush_req_d = 1'b0;
        bit_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_cnt_q   <= '0;
      flush_req_q  <= 1'b0;
      cur_q        <= 2'd0;
      first_q      <= 1'b0;
      tb_addr_q    <= '0;
      idx_q        <= '0;
      dec_buf_q    <= '0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_cnt_q   <= pend_cnt_d;
      flush_req_q  <= flush_req_d;
      cur_q        <= cur_d;
      first_q      <= first_d;
      tb_addr_q    <= tb_addr_d;
      idx_q        <= idx_d;
      dec_buf_q    <= dec_buf_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sym_ready_o  = sym_ready_s;
  assign bus.acs_valid_o  = write_s;
  assign bus.tb_addr_o    = tb_addr_q;
  assign bus.bit_o        = bit_q;
  assign bus.bit_valid_o  = bit_valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.flush_done_o = flush_done_q;

endmodule

// File: tb/tb_tbu_ctrl.sv
// Directed self-checking bench for tbu_ctrl (TBL = 15, PM_WIDTH = 8).
module tb_tbu_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tbu_ctrl_if #(.TBL(15), .PM_WIDTH(8)) bus ();

  tbu_ctrl #(.TBL(15), .PM_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pm(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    bus.pm_s0_i = a;
    bus.pm_s1_i = b;
    bus.pm_s2_i = c;
    bus.pm_s3_i = d;
  endtask

  initial begin
    logic [2:0] e_bits;
    checks = 0;
    errors = 0;

    // Reset with a symbol offered
    rst_n           = 1'b0;
    bus.sym_valid_i = 1'b1;
    bus.flush_i     = 1'b0;
    bus.bit_ready_i = 1'b0;
    bus.tb_data_i   = 4'b1111;
    set_pm(8'd5, 8'd5, 8'd5, 8'd0);
    repeat (3) tick();
    chk("rst_sym_ready", bus.sym_ready_o, 1'b0);
    chk("rst_acs_valid", bus.acs_valid_o, 1'b0);
    chk("rst_bit_valid", bus.bit_valid_o, 1'b0);
    chk("rst_bit", bus.bit_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_flush_done", bus.flush_done_o, 1'b0);
    chk("rst_tb_addr", bus.tb_addr_o, 4'd0);
    rst_n           = 1'b1;
    bus.sym_valid_i = 1'b0;
    #1;
    chk("rel_sym_ready", bus.sym_ready_o, 1'b1);

    // Fill 14 stages: no traceback yet
    bus.sym_valid_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("fill_busy", bus.busy_o, 1'b0);
      chk("fill_bit_valid", bus.bit_valid_o, 1'b0);
    end
    tick();
    chk("trace_busy", bus.busy_o, 1'b1);
    chk("trace_addr_first", bus.tb_addr_o, 4'd14);
    chk("trace_sym_ready", bus.sym_ready_o, 1'b0);
    chk("trace_acs_valid", bus.acs_valid_o, 1'b0);
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("trace_addr", bus.tb_addr_o, 32'(14 - k));
      chk("trace_no_bit", bus.bit_valid_o, 1'b0);
    end
    tick();
    chk("emit_valid", bus.bit_valid_o, 1'b1);
    chk("emit_bit_s3", bus.bit_o, 1'b1);

    // Backpressure: output stable, input stalled
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", bus.bit_valid_o, 1'b1);
      chk("bp_bit", bus.bit_o, 1'b1);
      chk("bp_sym_ready", bus.sym_ready_o, 1'b0);
      chk("bp_acs_valid", bus.acs_valid_o, 1'b0);
    end
    bus.bit_ready_i = 1'b1;
    bus.sym_valid_i = 1'b0;
    tick();
    chk("bp_rel_valid", bus.bit_valid_o, 1'b0);
    chk("bp_rel_busy", bus.busy_o, 1'b0);
    chk("bp_rel_ready", bus.sym_ready_o, 1'b1);

    // pend_cnt is 14: one write restarts traceback; tie picks s0
    set_pm(8'd3, 8'd3, 8'd3, 8'd3);
    bus.tb_data_i   = 4'b0000;
    bus.sym_valid_i = 1'b1;
    tick();
    bus.sym_valid_i = 1'b0;
    chk("one_write_busy", bus.busy_o, 1'b1);
    chk("one_write_addr", bus.tb_addr_o, 4'd14);
    repeat (15) tick();
    chk("tie_valid", bus.bit_valid_o, 1'b1);
    chk("tie_bit_s0", bus.bit_o, 1'b0);
    tick();
    chk("tie_accept_valid", bus.bit_valid_o, 1'b0);
    chk("tie_accept_busy", bus.busy_o, 1'b0);

    // Flush requested mid-TRACE; path 3 -> 2 -> 0 -> 0 ...
    set_pm(8'd5, 8'd5, 8'd5, 8'd0);
    bus.sym_valid_i = 1'b1;
    tick();
    bus.sym_valid_i = 1'b0;
    tick();
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (12) tick();
    chk("mid_normal_valid", bus.bit_valid_o, 1'b1);
    chk("mid_normal_bit", bus.bit_o, 1'b0);
    tick();
    chk("mid_idle_valid", bus.bit_valid_o, 1'b0);
    chk("mid_idle_ready", bus.sym_ready_o, 1'b0);
    tick();
    chk("mid_ftrace_busy", bus.busy_o, 1'b1);
    chk("mid_ftrace_addr", bus.tb_addr_o, 4'd14);
    repeat (15) tick();
    chk("mid_femit_valid", bus.bit_valid_o, 1'b1);
    chk("mid_femit_bit", bus.bit_o, 1'b0);
    tick();
    tick();
    chk("mid_femit_valid2", bus.bit_valid_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", bus.bit_valid_o, 1'b0);
    chk("abort_busy", bus.busy_o, 1'b0);
    chk("abort_sym_ready", bus.sym_ready_o, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_bit", bus.bit_valid_o, 1'b0);
      chk("abort_no_done", bus.flush_done_o, 1'b0);
    end

    // Flush with nothing pending
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("empty_flush_done", bus.flush_done_o, 1'b1);
    chk("empty_flush_busy", bus.busy_o, 1'b0);
    tick();
    chk("empty_flush_pulse", bus.flush_done_o, 1'b0);

    // Flush with 5 pending stages, all ones
    bus.tb_data_i   = 4'b1111;
    bus.sym_valid_i = 1'b1;
    repeat (5) tick();
    bus.sym_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("f5_busy", bus.busy_o, 1'b1);
    chk("f5_addr", bus.tb_addr_o, 4'd14);
    repeat (15) tick();
    for (int i = 0; i < 5; i++) begin
      chk("f5_valid", bus.bit_valid_o, 1'b1);
      chk("f5_bit", bus.bit_o, 1'b1);
      chk("f5_no_done", bus.flush_done_o, 1'b0);
      tick();
    end
    chk("f5_done", bus.flush_done_o, 1'b1);
    chk("f5_end_valid", bus.bit_valid_o, 1'b0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("f5_cnt_cleared", bus.flush_done_o, 1'b1);
    chk("f5_cnt_idle", bus.busy_o, 1'b0);

    // Flush of 3 stages, ordering oldest-first: buf[12..14] = 0,1,1
    e_bits          = 3'b110;
    bus.tb_data_i   = 4'b0000;
    bus.sym_valid_i = 1'b1;
    repeat (3) tick();
    bus.sym_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (15) tick();
    for (int i = 0; i < 3; i++) begin
      chk("f3_valid", bus.bit_valid_o, 1'b1);
      chk("f3_bit", bus.bit_o, e_bits[i]);
      tick();
    end
    chk("f3_done", bus.flush_done_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbu_ctrl.md
Name: tbu_ctrl

Overview:
- Traceback controller for the 4-state (K=3) Viterbi decoder.
- Gates the symbol stream into the ACSU/PMU with a valid/ready handshake and drives the PMU decision-memory read address.
- Walks the survivor path from the best-metric state and emits decoded bits with a valid/ready handshake.
- Stalls the input during traceback, because the PMU decision memory shifts on every write. Supports end-of-frame flush of the still-undecoded stages.

Parameters:
- TBL, 15: traceback length. Must equal the PMU decision-memory depth; TBL >= 2.
- PM_WIDTH, 8: path-metric width. Must equal the PMU width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low.
- sym_valid_i  in  1  upstream symbol pair available.
- sym_ready_o  out  1  controller accepts a symbol this cycle.
- acs_valid_o  out  1  write strobe to ACSU/PMU valid_i; = sym_valid_i & sym_ready_o (combinational).
- flush_i  in  1  end-of-frame request (pulse).
- pm_s0_i..pm_s3_i  in  PM_WIDTH each  current path metrics from PMU.
- tb_addr_o  out  $clog2(TBL)  decision-memory read address to PMU (registered).
- tb_data_i  in  4  decision word at tb_addr_o (combinational from PMU); bit s = decision of state s.
- bit_o  out  1  decoded bit.
- bit_valid_o  out  1  bit_o valid.
- bit_ready_i  in  1  downstream accepts bit.
- busy_o  out  1  high in any state other than IDLE.
- flush_done_o  out  1  one-cycle pulse when a flush completes.

Behaviour:
- State encoding s = {b1,b0}, where b1 is the newest input bit.
  - Predecessor of s = {s[0], tb_data_i[s]}.
  - Decoded bit at a stage = s[1] of the state on the path at that stage.
- Counter pend_cnt (0..TBL) holds the number of stored, undecoded stages.
  - +1 on each write (acs_valid_o).
  - -1 on each emitted bit (normal mode).
  - Cleared at flush end.
- FSM states: IDLE, TRACE, EMIT, FTRACE, FEMIT.
  - IDLE: sym_ready_o = !flush_req.
    - Write with pend_cnt+1 == TBL -> TRACE.
    - Else if flush_req (or flush_i) with pend_cnt > 0 -> FTRACE.
    - Else if flush with pend_cnt == 0 -> pulse flush_done_o and stay in IDLE.
  - TRACE/FTRACE, first cycle: cur = argmin(pm_s0..s3); ties go to the lowest index. tb_addr_o = TBL-1.
  - TRACE/FTRACE, each cycle:
    - buf[tb_addr_o] <= cur[1]
    - cur <= predecessor(cur)
    - tb_addr_o decrements
    - After addr 0 (TBL cycles): TRACE -> EMIT, FTRACE -> FEMIT.
  - EMIT: bit_valid_o = 1, bit_o = buf[0]. Holds until bit_ready_i, then pend_cnt -= 1 and -> IDLE.
  - FEMIT: emits buf[TBL-pend_cnt] .. buf[TBL-1] oldest-first, one per accepted handshake. After the last one: pend_cnt <= 0, flush_done_o pulse, flush_req clear, -> IDLE.
- Latency: write at edge N -> TRACE cycles N+1..N+TBL -> bit_valid_o high from cycle N+TBL+1.
  - Steady-state throughput: 1 bit per TBL+2 cycles with bit_ready_i held high.
- Output stability: bit_o and bit_valid_o stay stable while bit_valid_o & !bit_ready_i.
- flush_i arriving in any non-IDLE state, or together with an accepted write, sets flush_req. It is serviced on the next IDLE cycle; a pending TRACE/EMIT completes first.
- sym_ready_o = 0 in all non-IDLE states, so no PMU write (and no memory shift) occurs during traceback or emission.
- Reset (synchronous, rst_n low at an edge):
  - FSM -> IDLE; pend_cnt, flush_req, buf, cur -> 0; tb_addr_o -> 0.
  - bit_o, bit_valid_o, flush_done_o, busy_o -> 0.
  - Reset mid-traceback or mid-emission discards everything with no partial output.
  - While rst_n is low, sym_ready_o = 0.
- Path metrics are not reset by flush; frame-start PM bias is outside this block.

Test Plan:
- Reset with sym_valid_i = 1 -> sym_ready_o = 0, acs_valid_o = 0, all outputs 0. First cycle after release: sym_ready_o = 1.
- Fill with 14 writes (TBL = 15): no trace, bit_valid_o stays 0. 15th write at cycle N -> tb_addr_o sweeps 14..0 over N+1..N+15 -> bit_valid_o = 1 at N+16.
- PMs = {s0=5, s1=5, s2=5, s3=0}, all decision words 4'b1111 -> path stays in state 3 -> bit_o = 1. All PMs = 3 with words 4'b0000 -> argmin picks s0 -> bit_o = 0.
- Backpressure: bit_ready_i held 0 for 10 cycles during EMIT -> bit_o stable, sym_ready_o = 0 throughout. Release -> IDLE next cycle, pend_cnt = 14.
- Flush with pend_cnt = 5 (decision words 4'b1111, s3 minimal) -> one FTRACE pass, 5 bits of value 1 emitted, flush_done_o pulse, pend_cnt = 0.
- flush_i asserted mid-TRACE plus rst_n dropped mid-FEMIT -> normal bit is emitted first, then flush runs; reset aborts with no further bit_valid_o and no flush_done_o.
